// File: rtl/change_dispense_sequencer.sv
// Coin change payout sequencer: greedy largest-denomination ejection from four
// saturating 8-bit inventories, with an ack timeout that parks the machine in FAULT.
module change_dispense_sequencer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] change_amt,
  output logic       busy,
  output logic       done,
  output logic       fault,
  input  logic       fault_clr,
  output logic       eject_req,
  output logic [1:0] eject_denom,
  input  logic       eject_ack,
  output logic [7:0] remaining,
  input  logic       refill_valid,
  input  logic [1:0] refill_denom,
  input  logic [7:0] refill_count,
  input  logic [1:0] inv_sel,
  output logic [7:0] inv_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_EJECT  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam int WW = ($clog2(ACK_TIMEOUT + 1) < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

  logic [2:0]    state;
  logic [WW-1:0] wait_cnt;
  logic [7:0]    counts   [4];
  logic [7:0]    cnt_next [4];
  logic          sel_found;
  logic [1:0]    sel_idx;
  logic          ack_take;

  function automatic logic [7:0] denom_value(input logic [1:0] d);
    case (d)
      2'd0:    denom_value = 8'd1;
      2'd1:    denom_value = 8'd5;
      2'd2:    denom_value = 8'd10;
      default: denom_value = 8'd25;
    endcase
  endfunction

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign fault     = (state == S_FAULT);
  assign eject_req = (state == S_EJECT);
  assign inv_count = counts[inv_sel];
  assign ack_take  = (state == S_EJECT) && eject_ack;

  // Ascending scan so the last hit is the largest usable denomination.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (counts[i] != 8'd0 && denom_value(2'(i)) <= remaining) begin
        sel_found = 1'b1;
        sel_idx   = 2'(i);
      end
    end
  end

  // Refill and ack decrement merge in 9 bits, then saturate at 255 and floor at 0.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      logic [8:0] sum;
      sum = {1'b0, counts[i]};
      if (refill_valid && refill_denom == 2'(i)) sum = sum + {1'b0, refill_count};
      if (ack_take && eject_denom == 2'(i) && sum != 9'd0) sum = sum - 9'd1;
      cnt_next[i] = sum[8] ? 8'd255 : sum[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) counts[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) counts[i] <= cnt_next[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      remaining   <= 8'd0;
      wait_cnt    <= '0;
      eject_denom <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= change_amt;
            state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (remaining == 8'd0) begin
            state <= S_DONE;
          end else if (sel_found) begin
            eject_denom <= sel_idx;
            wait_cnt    <= '0;
            state       <= S_EJECT;
          end else begin
            state <= S_FAULT;
          end
        end
        S_EJECT: begin
          if (eject_ack) begin
            remaining <= remaining - denom_value(eject_denom);
            state     <= S_SELECT;
          end else if (wait_cnt == WW'(ACK_TIMEOUT)) begin
            state <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_FAULT: if (fault_clr) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
